// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode 7-segment driver: sequential binary-to-BCD conversion
// (shift-add-3), signed/hex/zero-blanking digit mapping and a registered digit scanner.
module seg_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 8,
    parameter int REFRESH_DIV = 4,
    parameter bit SIGNED      = 1'b1
) (
    input  logic                  display_clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     value_in,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    // Decimal digits needed for 2^DATA_W-1: floor(DATA_W*log10(2))+1.
    localparam int BCD_N   = (DATA_W * 30103) / 100000 + 1;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int NIB_N   = (DATA_W + 3) / 4;
    localparam int DIG_N   = (NUM_DIGITS > BCD_N) ? NUM_DIGITS : BCD_N;
    localparam int HEX_N   = (NUM_DIGITS > NIB_N) ? NUM_DIGITS : NIB_N;
    localparam bit HEX_OVF = (DATA_W > 4 * NUM_DIGITS);
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'b0000001;
            5'd1:    g = 7'b1001111;
            5'd2:    g = 7'b0010010;
            5'd3:    g = 7'b0000110;
            5'd4:    g = 7'b1001100;
            5'd5:    g = 7'b0100100;
            5'd6:    g = 7'b0100000;
            5'd7:    g = 7'b0001111;
            5'd8:    g = 7'b0000000;
            5'd9:    g = 7'b0000100;
            5'd10:   g = 7'b0001000;
            5'd11:   g = 7'b1100000;
            5'd12:   g = 7'b0110001;
            5'd13:   g = 7'b1000010;
            5'd14:   g = 7'b0110000;
            5'd15:   g = 7'b0111000;
            5'd16:   g = 7'b1111110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in bit_in.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                  input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    state_t                state_r;
    state_t                state_nx;
    logic                  hex_r;
    logic                  blz_r;
    logic                  sign_r;
    logic [DATA_W-1:0]     val_r;
    logic [DATA_W-1:0]     shift_r;
    logic [BCD_W-1:0]      bcd_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  busy_r;
    logic                  overflow_r;
    logic [4:0]            digit_r [NUM_DIGITS];
    logic [PRE_W-1:0]      pre_r;
    logic [IDX_W-1:0]      idx_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;

    logic                  neg_s;
    logic [DATA_W-1:0]     mag_s;
    logic [4:0]            dig_s [NUM_DIGITS];
    logic                  ovf_s;
    logic                  lead_s;
    logic [3:0]            nib_s;
    logic [4*DIG_N-1:0]    bcd_pad_s;
    logic [4*HEX_N-1:0]    hex_pad_s;
    logic [NUM_DIGITS-1:0] an_s;

    assign busy     = busy_r;
    assign overflow = overflow_r;
    assign an       = an_r;
    assign seg      = seg_r;

    // State register.
    always_ff @(posedge display_clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic: a load in IDLE starts DATA_W shift steps then one commit.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    state_nx = ST_SHIFT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(DATA_W - 1)) begin
                    state_nx = ST_COMMIT;
                end else begin
                    state_nx = ST_SHIFT;
                end
            end
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Sign/magnitude split of the incoming value; hex mode is always unsigned.
    always_comb begin
        neg_s = (!hex_mode) && (SIGNED != 1'b0) && value_in[DATA_W-1];
        if (neg_s) begin
            mag_s = ~value_in + DATA_W'(1);
        end else begin
            mag_s = value_in;
        end
    end

    // Map the finished conversion (or raw nibbles) onto per-digit glyph codes.
    always_comb begin
        bcd_pad_s = '0;
        bcd_pad_s[BCD_W-1:0] = bcd_r;
        hex_pad_s = '0;
        hex_pad_s[DATA_W-1:0] = val_r;
        lead_s = 1'b1;
        ovf_s  = 1'b0;
        nib_s  = 4'd0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            dig_s[j] = CODE_BLANK;
        end
        if (hex_r) begin
            ovf_s = HEX_OVF;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                nib_s = hex_pad_s[4*(NUM_DIGITS-1-j) +: 4];
                if (blz_r && lead_s && (nib_s == 4'd0) && (j != NUM_DIGITS - 1)) begin
                    dig_s[j] = CODE_BLANK;
                end else begin
                    lead_s   = 1'b0;
                    dig_s[j] = {1'b0, nib_s};
                end
            end
        end else begin
            // Any nonzero BCD digit at or above the sign-slot position cannot be shown.
            for (int i = 0; i < DIG_N; i++) begin
                if ((i >= NUM_DIGITS - 1) && (bcd_pad_s[4*i +: 4] != 4'd0)) begin
                    ovf_s = 1'b1;
                end else begin
                    ovf_s = ovf_s;
                end
            end
            dig_s[0] = sign_r ? CODE_DASH : CODE_BLANK;
            for (int j = 1; j < NUM_DIGITS; j++) begin
                nib_s = bcd_pad_s[4*(NUM_DIGITS-1-j) +: 4];
                if (blz_r && lead_s && (nib_s == 4'd0) && (j != NUM_DIGITS - 1)) begin
                    dig_s[j] = CODE_BLANK;
                end else begin
                    lead_s   = 1'b0;
                    dig_s[j] = {1'b0, nib_s};
                end
            end
        end
        if (ovf_s) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                dig_s[j] = CODE_DASH;
            end
        end else begin
            ovf_s = 1'b0;
        end
    end

    // Conversion datapath: capture on load, shift-add-3 per step, commit digits.
    // shift_r rotates so every bit stays live; after DATA_W steps it holds mag again.
    always_ff @(posedge display_clk) begin
        if (!rst_n) begin
            hex_r      <= 1'b0;
            blz_r      <= 1'b0;
            sign_r     <= 1'b0;
            val_r      <= '0;
            shift_r    <= '0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
            for (int j = 0; j < NUM_DIGITS; j++) begin
                digit_r[j] <= CODE_BLANK;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load) begin
                        hex_r   <= hex_mode;
                        blz_r   <= blank_lz;
                        sign_r  <= neg_s;
                        val_r   <= value_in;
                        shift_r <= mag_s;
                        bcd_r   <= '0;
                        cnt_r   <= '0;
                    end
                end
                ST_SHIFT: begin
                    bcd_r   <= bcd_step(bcd_r, shift_r[DATA_W-1]);
                    shift_r <= {shift_r[DATA_W-2:0], shift_r[DATA_W-1]};
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
                ST_COMMIT: begin
                    digit_r    <= dig_s;
                    overflow_r <= ovf_s;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
            busy_r <= (state_nx != ST_IDLE);
        end
    end

    // Active-low one-hot enable for the current scan index (digit 0 on the MSB).
    always_comb begin
        an_s = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx_r == IDX_W'(j)) begin
                an_s[NUM_DIGITS-1-j] = 1'b0;
            end else begin
                an_s[NUM_DIGITS-1-j] = 1'b1;
            end
        end
    end

    // Refresh prescaler, scan index and registered pin drivers.
    always_ff @(posedge display_clk) begin
        if (!rst_n) begin
            pre_r <= '0;
            idx_r <= '0;
            an_r  <= '1;
            seg_r <= 7'b1111111;
        end else begin
            if (pre_r == PRE_W'(REFRESH_DIV - 1)) begin
                pre_r <= '0;
                if (idx_r == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_r <= '0;
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                pre_r <= pre_r + PRE_W'(1);
            end
            an_r  <= an_s;
            seg_r <= glyph(digit_r[idx_r]);
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: a 4-digit signed instance and a 3-digit
// unsigned instance; monitors capture one full scan after each busy fall.
module tb_seg_display_ctrl;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b1100000;
    localparam logic [6:0] DS = 7'b1111110;
    localparam logic [6:0] BL = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value_in;
    logic       load;
    logic       hex_mode;
    logic       blank_lz;
    logic       busy;
    logic       overflow;
    logic [3:0] an;
    logic [6:0] seg;
    logic [7:0] value3;
    logic       load3;
    logic       hex3;
    logic       blz3;
    logic       busy3;
    logic       ovf3;
    logic [2:0] an3;
    logic [6:0] seg3;

    int tests = 0;
    int fails = 0;
    logic [28:0] q4 [$];
    logic [21:0] q3 [$];

    always #5 clk = ~clk;

    seg_display_ctrl #(.NUM_DIGITS(4), .DATA_W(8), .REFRESH_DIV(4), .SIGNED(1'b1)) dut (
        .display_clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .busy(busy), .overflow(overflow),
        .an(an), .seg(seg)
    );

    seg_display_ctrl #(.NUM_DIGITS(3), .DATA_W(8), .REFRESH_DIV(4), .SIGNED(1'b0)) dut3 (
        .display_clk(clk), .rst_n(rst_n), .value_in(value3), .load(load3),
        .hex_mode(hex3), .blank_lz(blz3), .busy(busy3), .overflow(ovf3),
        .an(an3), .seg(seg3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] e4(input logic o, input logic [6:0] a, input logic [6:0] b,
                                       input logic [6:0] c, input logic [6:0] d);
        return {o, a, b, c, d};
    endfunction

    function automatic logic [28:0] e3(input logic o, input logic [6:0] a, input logic [6:0] b,
                                       input logic [6:0] c);
        return {7'b0000000, o, a, b, c};
    endfunction

    task automatic wait_scoreboard();
        int n;
        n = 0;
        while ((q4.size() + q3.size()) != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if ((q4.size() + q3.size()) != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_timeout: %0d entries still pending", q4.size() + q3.size());
            q4.delete();
            q3.delete();
        end
    endtask

    // Issue one load; optionally attempt a second load while busy (must be ignored).
    task automatic do_load(input bit sel, input logic [7:0] v, input logic hx, input logic bz,
                           input logic [28:0] exp, input bit intrude);
        int n;
        @(negedge clk);
        if (sel == 1'b0) begin
            value_in = v; hex_mode = hx; blank_lz = bz; load = 1'b1;
            q4.push_back(exp);
        end else begin
            value3 = v; hex3 = hx; blz3 = bz; load3 = 1'b1;
            q3.push_back(exp[21:0]);
        end
        @(negedge clk);
        load  = 1'b0;
        load3 = 1'b0;
        n = 0;
        while (((sel == 1'b0) ? busy : busy3) && n < 40) begin
            n++;
            if (intrude && n == 3) begin
                value_in = 8'h00; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("busy_cycles", n, 32'd9);
        wait_scoreboard();
    endtask

    // Monitor for the 4-digit instance.
    initial begin
        logic [6:0]  cap [4];
        logic        bad;
        logic [28:0] e;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge busy);
            @(negedge clk);
            for (int d = 0; d < 4; d++) cap[d] = 7'b0000000;
            bad = 1'b0;
            repeat (16) begin
                @(negedge clk);
                case (an)
                    4'b0111: cap[0] = seg;
                    4'b1011: cap[1] = seg;
                    4'b1101: cap[2] = seg;
                    4'b1110: cap[3] = seg;
                    default: bad = 1'b1;
                endcase
            end
            if (q4.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon4_unexpected: busy fell with no pending expectation");
            end else begin
                e = q4.pop_front();
                for (int d = 0; d < 4; d++) check($sformatf("mon4_digit%0d", d), cap[d], e[27-7*d -: 7]);
                check("mon4_overflow", overflow, e[28]);
                check("mon4_an_onehot", bad, 32'd0);
            end
        end
    end

    // Monitor for the 3-digit instance.
    initial begin
        logic [6:0]  cap [3];
        logic        bad;
        logic [21:0] e;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge busy3);
            @(negedge clk);
            for (int d = 0; d < 3; d++) cap[d] = 7'b0000000;
            bad = 1'b0;
            repeat (12) begin
                @(negedge clk);
                case (an3)
                    3'b011:  cap[0] = seg3;
                    3'b101:  cap[1] = seg3;
                    3'b110:  cap[2] = seg3;
                    default: bad = 1'b1;
                endcase
            end
            if (q3.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon3_unexpected: busy fell with no pending expectation");
            end else begin
                e = q3.pop_front();
                for (int d = 0; d < 3; d++) check($sformatf("mon3_digit%0d", d), cap[d], e[20-7*d -: 7]);
                check("mon3_overflow", ovf3, e[21]);
                check("mon3_an_onehot", bad, 32'd0);
            end
        end
    end

    // Stimulus.
    initial begin
        logic [3:0] ea;
        rst_n = 1'b0;
        value_in = 8'h00; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
        value3 = 8'h00; load3 = 1'b0; hex3 = 1'b0; blz3 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 32'd0);
        check("rst_overflow", overflow, 32'd0);
        check("rst_an", an, 32'hF);
        check("rst_seg", seg, 32'h7F);
        check("rst_an3", an3, 32'h7);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ea = ~(4'b1000 >> (i / 4));
            check("scan_an", an, ea);
            check("scan_seg", seg, 32'h7F);
        end

        do_load(1'b0, 8'hF3, 1'b0, 1'b0, e4(1'b0, DS, G0, G1, G3), 1'b0);
        do_load(1'b0, 8'h80, 1'b0, 1'b1, e4(1'b0, DS, G1, G2, G8), 1'b0);
        do_load(1'b0, 8'h05, 1'b0, 1'b1, e4(1'b0, BL, BL, BL, G5), 1'b0);
        do_load(1'b0, 8'h00, 1'b0, 1'b1, e4(1'b0, BL, BL, BL, G0), 1'b0);
        do_load(1'b0, 8'h7F, 1'b0, 1'b0, e4(1'b0, BL, G1, G2, G7), 1'b0);
        do_load(1'b0, 8'hAB, 1'b1, 1'b1, e4(1'b0, BL, BL, GA, GB), 1'b1);

        // Reset at the fourth shift step: conversion aborted, old digits gone.
        @(negedge clk);
        value_in = 8'h42; hex_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        q4.push_back(e4(1'b0, BL, BL, BL, BL));
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 32'd0);
        check("abort_an", an, 32'hF);
        check("abort_seg", seg, 32'h7F);
        rst_n = 1'b1;
        wait_scoreboard();

        do_load(1'b1, 8'd100, 1'b0, 1'b0, e3(1'b1, DS, DS, DS), 1'b0);
        do_load(1'b1, 8'd99,  1'b0, 1'b0, e3(1'b0, BL, G9, G9), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
